// File: rtl/sram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_if
//   Bundle of one sram-like request port: request fields travel from the
//   requesting side to the responding side; addr_ok/data_ok/rdata travel back.
//
//   Signals
//     req      request valid (held with its fields until addr_ok)
//     wr       1 = store, 0 = load
//     size     0 = byte, 1 = half, 2 = word
//     addr     ADDR_W-bit address
//     wdata    DATA_W-bit store data, lanes already aligned
//     addr_ok  address phase accepted
//     data_ok  load data valid / store complete
//     rdata    DATA_W-bit raw read word
//
//   Modports
//     master   the side that issues requests
//     slave    the side that answers them
// ---------------------------------------------------------------------------
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//   Shares one sram-like memory port between the fetch stage (inst) and the
//   mem stage (data). One transaction is in flight at a time: IDLE picks an
//   owner, ADDR forwards the owner's live request until addr_ok, DATA waits
//   for data_ok and routes it back. Ties alternate so neither side starves.
//
//   Ports
//     clk    clock
//     reset  synchronous reset, active-high
//     inst   slave  fetch requester (read-only; wr/size/wdata are ignored,
//                   the memory always sees a word load)
//     data   slave  mem-stage requester (loads and stores)
//     mem    master shared memory port
//
//   Both rdata outputs are a straight copy of mem.rdata; only data_ok makes
//   them meaningful.
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  sram_req_arbiter_if.slave   inst,
  sram_req_arbiter_if.slave   data,
  sram_req_arbiter_if.master  mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state;
  logic   owner;       // 0 = inst, 1 = data
  logic   last_owner;  // owner of the most recently issued transaction
  logic   owner_req;

  // The fetch side is read-only; its write fields are deliberately unused.
  logic   unused_inst_fields;
  assign unused_inst_fields = ^{inst.wr, inst.size, inst.wdata};

  assign owner_req = owner ? data.req : inst.req;

  // Read data goes to both requesters unconditionally.
  assign inst.rdata = mem.rdata;
  assign data.rdata = mem.rdata;

  // Arbitration FSM: owner selection, address handshake, data handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b0;  // so the first tie goes to data
    end else begin
      case (state)
        ST_IDLE: begin
          if (inst.req && data.req) begin
            owner <= ~last_owner;
            state <= ST_ADDR;
          end else if (data.req) begin
            owner <= 1'b1;
            state <= ST_ADDR;
          end else if (inst.req) begin
            owner <= 1'b0;
            state <= ST_ADDR;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (!owner_req) begin
            // Owner withdrew before acceptance: nothing was issued.
            state <= ST_IDLE;
          end else if (mem.addr_ok) begin
            last_owner <= owner;
            state      <= ST_DATA;
          end else begin
            state <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (mem.data_ok) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_DATA;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake routing and request mux; data_ok outside DATA is a protocol
  // error and never reaches a requester.
  always_comb begin
    mem.req       = 1'b0;
    mem.wr        = 1'b0;
    mem.size      = 2'b00;
    mem.addr      = {ADDR_W{1'b0}};
    mem.wdata     = {DATA_W{1'b0}};
    inst.addr_ok  = 1'b0;
    inst.data_ok  = 1'b0;
    data.addr_ok  = 1'b0;
    data.data_ok  = 1'b0;
    case (state)
      ST_ADDR: begin
        mem.req = owner_req;
        if (owner) begin
          mem.wr       = data.wr;
          mem.size     = data.size;
          mem.addr     = data.addr;
          mem.wdata    = data.wdata;
          data.addr_ok = owner_req & mem.addr_ok;
        end else begin
          mem.wr       = 1'b0;
          mem.size     = 2'b10;
          mem.addr     = inst.addr;
          mem.wdata    = {DATA_W{1'b0}};
          inst.addr_ok = owner_req & mem.addr_ok;
        end
      end
      ST_DATA: begin
        if (owner) begin
          data.data_ok = mem.data_ok;
        end else begin
          inst.data_ok = mem.data_ok;
        end
      end
      default: begin
        mem.req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
//   Directed bench for sram_req_arbiter. Inputs change 1 time unit after the
//   rising edge, outputs are compared 1 time unit later.
//   Handshake vector layout used by hs():
//     [4] inst.addr_ok  [3] inst.data_ok  [2] data.addr_ok  [1] data.data_ok
//     [0] mem.req
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) inst_if ();
  sram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) data_if ();
  sram_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  sram_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .mem   (mem_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hs(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok,
              data_if.data_ok, mem_if.req}, {27'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit own_data;

    // ---------------- reset, with a stray data_ok present ----------------
    reset         = 1'b1;
    inst_if.req   = 1'b0;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'b10;
    inst_if.addr  = 32'h0000_0000;
    inst_if.wdata = 32'h0000_0000;
    data_if.req   = 1'b0;
    data_if.wr    = 1'b0;
    data_if.size  = 2'b00;
    data_if.addr  = 32'h0000_0000;
    data_if.wdata = 32'h0000_0000;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = 32'h0000_0000;
    cyc();
    cyc();
    #1;
    hs("reset_hs", 5'b00000);
    chk("reset_m_wr", {31'd0, mem_if.wr}, 32'd0);
    chk("reset_m_size", {30'd0, mem_if.size}, 32'd0);
    chk("reset_m_addr", mem_if.addr, 32'd0);
    chk("reset_m_wdata", mem_if.wdata, 32'd0);
    reset          = 1'b0;
    mem_if.data_ok = 1'b0;

    // ---------------- 1: lone fetch ----------------
    cyc();
    inst_if.req    = 1'b1;
    inst_if.addr   = 32'hBFC0_0000;
    mem_if.addr_ok = 1'b1;
    #1;
    hs("t1_idle", 5'b00000);
    cyc();
    #1;
    hs("t1_addr", 5'b10001);
    chk("t1_m_addr", mem_if.addr, 32'hBFC0_0000);
    chk("t1_m_size", {30'd0, mem_if.size}, 32'd2);
    chk("t1_m_wr", {31'd0, mem_if.wr}, 32'd0);
    cyc();
    inst_if.req    = 1'b0;
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = 32'h3C08_0001;
    #1;
    hs("t1_data", 5'b01000);
    chk("t1_inst_rdata", inst_if.rdata, 32'h3C08_0001);
    cyc();
    mem_if.data_ok = 1'b0;
    #1;
    hs("t1_back_idle", 5'b00000);

    // ---------------- 2: both held high, alternate grants ----------------
    cyc();
    data_if.req    = 1'b1;
    data_if.wr     = 1'b0;
    data_if.size   = 2'b10;
    data_if.addr   = 32'h0000_2000;
    inst_if.req    = 1'b1;
    inst_if.addr   = 32'h0000_3000;
    mem_if.data_ok = 1'b1;  // stays high: ignored outside DATA
    #1;
    for (int i = 0; i < 4; i++) begin
      own_data = ((i % 2) == 0);
      hs("t2_idle", 5'b00000);
      cyc();
      #1;
      hs("t2_addr", own_data ? 5'b00101 : 5'b10001);
      chk("t2_m_addr", mem_if.addr, own_data ? 32'h0000_2000 : 32'h0000_3000);
      cyc();
      #1;
      hs("t2_data", own_data ? 5'b00010 : 5'b01000);
      cyc();
      #1;
    end
    inst_if.req    = 1'b0;
    data_if.req    = 1'b0;
    mem_if.data_ok = 1'b0;

    // ---------------- 3: byte store ----------------
    cyc();
    data_if.req   = 1'b1;
    data_if.wr    = 1'b1;
    data_if.size  = 2'b00;
    data_if.addr  = 32'h1000_0003;
    data_if.wdata = 32'hAB00_0000;
    #1;
    hs("t3_idle", 5'b00000);
    cyc();
    #1;
    hs("t3_addr", 5'b00101);
    chk("t3_m_wr", {31'd0, mem_if.wr}, 32'd1);
    chk("t3_m_size", {30'd0, mem_if.size}, 32'd0);
    chk("t3_m_addr", mem_if.addr, 32'h1000_0003);
    chk("t3_m_wdata", mem_if.wdata, 32'hAB00_0000);
    cyc();
    data_if.req    = 1'b0;
    data_if.wr     = 1'b0;
    data_if.wdata  = 32'h0000_0000;
    mem_if.data_ok = 1'b1;
    #1;
    hs("t3_data", 5'b00010);
    cyc();
    mem_if.data_ok = 1'b0;
    #1;
    hs("t3_back_idle", 5'b00000);

    // ---------------- 4: addr_ok withheld, competing fetch ----------------
    cyc();
    data_if.req    = 1'b1;
    data_if.size   = 2'b10;
    data_if.addr   = 32'h1000_0040;
    mem_if.addr_ok = 1'b0;
    #1;
    cyc();
    inst_if.req  = 1'b1;
    inst_if.addr = 32'h0000_4000;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        cyc();
        #1;
      end
      hs("t4_wait", 5'b00001);
      chk("t4_m_addr_stable", mem_if.addr, 32'h1000_0040);
      chk("t4_m_size_stable", {30'd0, mem_if.size}, 32'd2);
    end
    cyc();
    mem_if.addr_ok = 1'b1;
    #1;
    hs("t4_accept", 5'b00101);
    cyc();
    data_if.req = 1'b0;
    #1;
    hs("t4_data_wait", 5'b00000);
    cyc();
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = 32'h5555_AAAA;
    #1;
    hs("t4_data", 5'b00010);
    chk("t4_data_rdata", data_if.rdata, 32'h5555_AAAA);
    cyc();
    mem_if.data_ok = 1'b0;
    #1;
    hs("t4_idle", 5'b00000);
    cyc();
    #1;
    hs("t4_inst_addr", 5'b10001);
    chk("t4_inst_m_addr", mem_if.addr, 32'h0000_4000);
    cyc();
    inst_if.req    = 1'b0;
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = 32'h1234_5678;
    #1;
    hs("t4_inst_data", 5'b01000);
    chk("t4_inst_rdata", inst_if.rdata, 32'h1234_5678);
    cyc();
    mem_if.data_ok = 1'b0;
    #1;

    // ---------------- 5: reset during DATA ----------------
    cyc();
    data_if.req  = 1'b1;
    data_if.addr = 32'h0000_6000;
    #1;
    cyc();
    #1;
    hs("t5_addr", 5'b00101);
    cyc();
    data_if.req = 1'b0;
    #1;
    hs("t5_data_pending", 5'b00000);
    reset = 1'b1;
    cyc();
    reset          = 1'b0;
    mem_if.data_ok = 1'b1;
    data_if.req    = 1'b1;
    inst_if.req    = 1'b1;
    inst_if.addr   = 32'h0000_7000;
    #1;
    hs("t5_after_reset", 5'b00000);
    cyc();
    #1;
    hs("t5_tie_data", 5'b00101);
    chk("t5_tie_m_addr", mem_if.addr, 32'h0000_6000);
    cyc();
    data_if.req = 1'b0;
    inst_if.req = 1'b0;
    #1;
    hs("t5_data", 5'b00010);
    cyc();
    mem_if.data_ok = 1'b0;
    #1;
    hs("t5_back_idle", 5'b00000);

    // ---------------- 6: owner withdraws in ADDR ----------------
    cyc();
    data_if.req    = 1'b1;
    data_if.addr   = 32'h0000_8000;
    mem_if.addr_ok = 1'b0;
    #1;
    cyc();
    #1;
    hs("t6_addr", 5'b00001);
    data_if.req = 1'b0;
    #1;
    hs("t6_drop", 5'b00000);
    cyc();
    mem_if.data_ok = 1'b1;
    #1;
    hs("t6_idle", 5'b00000);
    cyc();
    #1;
    hs("t6_idle2", 5'b00000);
    mem_if.data_ok = 1'b0;
    mem_if.addr_ok = 1'b1;
    data_if.req    = 1'b1;
    data_if.addr   = 32'h0000_9000;
    cyc();
    #1;
    hs("t6_regrant", 5'b00101);
    chk("t6_regrant_m_addr", mem_if.addr, 32'h0000_9000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
